// File: rtl/lsu_dbus_ctrl_pkg.sv
// Shared types for the load/store unit and its dbus: access sizes, bus structs, LSU states.
package lsu_dbus_ctrl_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDrain,
    StResp
  } lsu_state_t;

  function automatic logic [3:0] msize_bytes(msize_t size);
    case (size)
      MSIZE1:  return 4'd1;
      MSIZE2:  return 4'd2;
      MSIZE4:  return 4'd4;
      MSIZE8:  return 4'd8;
      default: return 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_dbus_ctrl_if.sv
// Core-side op handshake plus dbus request/response bundled for the load/store unit.
interface lsu_dbus_ctrl_if;
  import lsu_dbus_ctrl_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  msize_t      req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        flush;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_misalign;
  logic        resp_timeout;
  dbus_req_t   dreq;
  dbus_resp_t  dresp;

  // Drives ops and plays the bus (core + dbus side).
  modport master (
    output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, flush, dresp,
    input  req_ready, resp_valid, resp_rdata, resp_misalign, resp_timeout, dreq
  );

  // The load/store unit itself.
  modport slave (
    input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, flush, dresp,
    output req_ready, resp_valid, resp_rdata, resp_misalign, resp_timeout, dreq
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for a 64-bit data bus: store strobe/data shift and load extract/extend.
module lsu_lane_align
  import lsu_dbus_ctrl_pkg::*;
(
  input  msize_t      i_size,
  input  logic [2:0]  i_offset,
  input  logic        i_store,
  input  logic        i_unsigned,
  input  logic [63:0] i_wdata,
  input  logic [63:0] i_rdata,
  output logic [7:0]  o_strobe,
  output logic [63:0] o_wdata,
  output logic [63:0] o_rdata
);

  logic [5:0]  w_shamt;
  logic [7:0]  w_lane_mask;
  logic [63:0] w_rshift;
  logic        w_sext;

  assign w_shamt  = {i_offset, 3'b000};
  assign w_rshift = i_rdata >> w_shamt;
  assign o_wdata  = i_wdata << w_shamt;
  assign o_strobe = i_store ? (w_lane_mask << i_offset) : 8'h00;

  always_comb begin
    w_lane_mask = 8'hFF;
    w_sext      = 1'b0;
    o_rdata     = w_rshift;
    case (i_size)
      MSIZE1: begin
        w_lane_mask = 8'h01;
        w_sext      = ~i_unsigned & w_rshift[7];
        o_rdata     = {{56{w_sext}}, w_rshift[7:0]};
      end
      MSIZE2: begin
        w_lane_mask = 8'h03;
        w_sext      = ~i_unsigned & w_rshift[15];
        o_rdata     = {{48{w_sext}}, w_rshift[15:0]};
      end
      MSIZE4: begin
        w_lane_mask = 8'h0F;
        w_sext      = ~i_unsigned & w_rshift[31];
        o_rdata     = {{32{w_sext}}, w_rshift[31:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_dbus_ctrl.sv
// Load/store unit: accepts one op per handshake, holds dreq until data_ok, returns extended data.
module lsu_dbus_ctrl
  import lsu_dbus_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 0,
  parameter bit          RESP_REG    = 1'b1,
  parameter int unsigned CNT_W       = 16
) (
  input logic            clk,
  input logic            resetn,
  lsu_dbus_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT_CYC);
  localparam bit               WdogEn     = (TIMEOUT_CYC != 0);

  lsu_state_t       r_state;
  logic             r_valid;
  logic [63:0]      r_addr;
  msize_t           r_size;
  logic             r_store;
  logic             r_unsigned;
  logic [63:0]      r_wdata;
  logic [CNT_W-1:0] r_cnt;
  logic             r_resp_misalign;
  logic             r_resp_timeout;
  logic [63:0]      r_resp_rdata;

  logic        w_accept;
  logic        w_req_misalign;
  logic [2:0]  w_req_mask;
  logic        w_data_ok;
  logic        w_timeout;
  logic [7:0]  w_strobe;
  logic [63:0] w_wdata_sh;
  logic [63:0] w_load_data;
  logic        w_fire;
  logic        w_misalign;
  logic        w_tmo;
  logic [63:0] w_rdata;
  logic        w_out_valid;
  logic        w_out_misalign;
  logic        w_out_timeout;
  logic [63:0] w_out_rdata;

  assign w_accept       = (r_state == StIdle) && bus.req_valid && !bus.flush;
  assign w_req_mask     = 3'(msize_bytes(bus.req_size) - 4'd1);
  assign w_req_misalign = (bus.req_addr[2:0] & w_req_mask) != 3'd0;
  assign w_data_ok      = bus.dresp.data_ok;
  assign w_timeout      = WdogEn && (r_cnt == TimeoutVal) && !w_data_ok;

  lsu_lane_align u_lane_align (
    .i_size     (r_size),
    .i_offset   (r_addr[2:0]),
    .i_store    (r_store),
    .i_unsigned (r_unsigned),
    .i_wdata    (r_wdata),
    .i_rdata    (bus.dresp.data),
    .o_strobe   (w_strobe),
    .o_wdata    (w_wdata_sh),
    .o_rdata    (w_load_data)
  );

  assign bus.dreq = '{valid: r_valid, addr: r_addr, size: r_size, strobe: w_strobe,
                      data: w_wdata_sh};

  // Completion event in the current cycle; flush here means nobody wants the answer.
  always_comb begin
    w_fire     = 1'b0;
    w_misalign = 1'b0;
    w_tmo      = 1'b0;
    w_rdata    = '0;
    case (r_state)
      StIdle: begin
        if (w_accept && w_req_misalign) begin
          w_fire     = 1'b1;
          w_misalign = 1'b1;
        end
      end
      StBusy: begin
        if (!bus.flush) begin
          if (w_data_ok) begin
            w_fire  = 1'b1;
            w_rdata = r_store ? '0 : w_load_data;
          end else if (w_timeout) begin
            w_fire = 1'b1;
            w_tmo  = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state         <= StIdle;
      r_valid         <= 1'b0;
      r_addr          <= '0;
      r_size          <= MSIZE1;
      r_store         <= 1'b0;
      r_unsigned      <= 1'b0;
      r_wdata         <= '0;
      r_cnt           <= '0;
      r_resp_misalign <= 1'b0;
      r_resp_timeout  <= 1'b0;
      r_resp_rdata    <= '0;
    end else begin
      r_resp_misalign <= w_misalign;
      r_resp_timeout  <= w_tmo;
      r_resp_rdata    <= w_rdata;
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            if (w_req_misalign) begin
              if (RESP_REG) r_state <= StResp;
            end else begin
              r_state    <= StBusy;
              r_valid    <= 1'b1;
              r_addr     <= bus.req_addr;
              r_size     <= bus.req_size;
              r_store    <= bus.req_store;
              r_unsigned <= bus.req_unsigned;
              r_wdata    <= bus.req_wdata;
              r_cnt      <= '0;
            end
          end
        end
        StBusy: begin
          if (w_data_ok || w_timeout) begin
            r_valid <= 1'b0;
            if (RESP_REG && !bus.flush) r_state <= StResp;
            else                        r_state <= StIdle;
          end else if (bus.flush) begin
            // Bus op stays in flight; only its answer is dropped.
            r_state <= StDrain;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        StDrain: begin
          if (w_data_ok || w_timeout) begin
            r_valid <= 1'b0;
            r_state <= StIdle;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    if (RESP_REG) begin
      w_out_valid    = (r_state == StResp) && !bus.flush;
      w_out_misalign = r_resp_misalign;
      w_out_timeout  = r_resp_timeout;
      w_out_rdata    = r_resp_rdata;
    end else begin
      w_out_valid    = w_fire;
      w_out_misalign = w_misalign;
      w_out_timeout  = w_tmo;
      w_out_rdata    = w_rdata;
    end
  end

  assign bus.req_ready     = (r_state == StIdle);
  assign bus.resp_valid    = w_out_valid;
  assign bus.resp_misalign = w_out_valid & w_out_misalign;
  assign bus.resp_timeout  = w_out_valid & w_out_timeout;
  assign bus.resp_rdata    = w_out_valid ? w_out_rdata : '0;

endmodule
